// File: rtl/bin2bcd_display_feeder_pkg.sv
// Shared types and constants for the binary-to-BCD display feeder.
// Register offsets, status bit positions, FSM encoding, pow10 helper.
package bin2bcd_display_feeder_pkg;

  localparam logic [1:0] REG_VALUE  = 2'd0;
  localparam logic [1:0] REG_RESULT = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_DONE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_display_feeder_bcd_adjust.sv
// Double-dabble nibble correction: +3 on every BCD nibble >= 5.
// Ports: nib_i (DIGITS nibbles in), nib_o (adjusted nibbles out).
module bin2bcd_display_feeder_bcd_adjust #(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4-1:0] nib_i,
  output logic [DIGITS*4-1:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (nib_i[i*4 +: 4] >= 4'd5)
        nib_o[i*4 +: 4] = nib_i[i*4 +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_display_feeder.sv
// Bus peripheral: converts a written binary value to packed BCD and
// writes it once to the display digit store. Ports: clk, reset (async
// active-low), strobe/rw/addr/d_in/d_out bus, busy, out_* display write.
module bin2bcd_display_feeder
  import bin2bcd_display_feeder_pkg::*;
#(
  parameter int          IN_BITS   = 14,
  parameter int          DIGITS    = 4,
  parameter logic [31:0] DISP_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        busy,
  output logic        out_strobe,
  output logic        out_rw,
  output logic [31:0] out_addr,
  output logic [31:0] out_data
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(IN_BITS + 1);
  localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);
  localparam logic [BW-1:0] ALL9 = {DIGITS{4'h9}};

  state_e              state_q;
  logic [IN_BITS-1:0]  value_q, bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d, result_q, adj;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q, done_q;
  logic                ostb_q, orw_q;
  logic [31:0]         oaddr_q, odata_q;

  logic [IN_BITS-1:0]  win;
  logic                wr_val, wr_stat, fits;
  logic [BW+IN_BITS-1:0] sh;

  assign win     = d_in[IN_BITS-1:0];
  assign wr_val  = strobe && rw && (addr[1:0] == REG_VALUE);
  assign wr_stat = strobe && rw && (addr[1:0] == REG_STATUS);
  assign fits    = 32'(win) <= MAX_VAL;

  bin2bcd_display_feeder_bcd_adjust #(
    .DIGITS(DIGITS)
  ) u_bcd_adjust (
    .nib_i(bcd_q),
    .nib_o(adj)
  );

  assign sh    = {adj, bin_q} << 1;
  assign bcd_d = sh[BW+IN_BITS-1:IN_BITS];
  assign bin_d = sh[IN_BITS-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      value_q  <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ostb_q   <= 1'b0;
      orw_q    <= 1'b0;
      oaddr_q  <= '0;
      odata_q  <= '0;
    end else begin
      // Clear first so a same-cycle done-set below wins.
      if (wr_stat) begin
        ovf_q  <= 1'b0;
        done_q <= 1'b0;
      end
      ostb_q  <= 1'b0;
      orw_q   <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (wr_val) begin
            value_q <= win;
            done_q  <= 1'b0;
            if (fits) begin
              bin_q   <= win;
              bcd_q   <= '0;
              cnt_q   <= CW'(IN_BITS);
              state_q <= ST_SHIFT;
            end else begin
              ovf_q    <= 1'b1;
              result_q <= ALL9;
              ostb_q   <= 1'b1;
              orw_q    <= 1'b1;
              oaddr_q  <= DISP_ADDR;
              odata_q  <= 32'(ALL9);
              state_q  <= ST_EMIT;
            end
          end
        end
        ST_SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= bcd_d;
            ostb_q   <= 1'b1;
            orw_q    <= 1'b1;
            oaddr_q  <= DISP_ADDR;
            odata_q  <= 32'(bcd_d);
            state_q  <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign out_strobe = ostb_q;
  assign out_rw     = orw_q;
  assign out_addr   = oaddr_q;
  assign out_data   = odata_q;

  always_comb begin
    d_out = '0;
    unique case (1'b1)
      addr[1:0] == REG_VALUE:  d_out = 32'(value_q);
      addr[1:0] == REG_RESULT: d_out = 32'(result_q);
      addr[1:0] == REG_STATUS: begin
        d_out[STAT_BUSY] = busy;
        d_out[STAT_OVF]  = ovf_q;
        d_out[STAT_DONE] = done_q;
      end
      default: d_out = '0;
    endcase
  end

  logic unused;
  assign unused = &{1'b0, addr[31:2], d_in[31:IN_BITS]};

endmodule

// File: doc/bin2bcd_display_feeder.md
Name: bin2bcd_display_feeder

Overview:
- Memory-mapped peripheral that sits directly upstream of the 7-segment display driver.
- Software writes a binary value; the block converts it iteratively to packed BCD (double-dabble, one bit per cycle).
- It then issues a single write of the BCD word into the display driver's digit-store register (offset 0).
- Status and result are readable over the same strobe/rw/addr/d_in/d_out bus the display uses.

Parameters:
- IN_BITS, 14: width of the binary input field (d_in[IN_BITS-1:0]).
- DIGITS, 4: BCD digits produced; result width DIGITS*4.
- DISP_ADDR, 32'h0: address driven on out_addr when writing the display digit store.

Ports:
- clk  in  1  single clock; all state on posedge clk.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- strobe  in  1  bus access valid this cycle.
- rw  in  1  1 = write, 0 = read.
- addr  in  32  register select; only addr[1:0] decoded.
- d_in  in  32  write data.
- d_out  out  32  read data, combinational from addr[1:0].
- busy  out  1  conversion or emit in progress.
- out_strobe  out  1  one-cycle write strobe to display driver.
- out_rw  out  1  constant 1 whenever out_strobe is high; 0 otherwise.
- out_addr  out  32  DISP_ADDR while out_strobe is high; 0 otherwise.
- out_data  out  32  zero-extended BCD result, valid while out_strobe is high.

Behaviour:
- Register map, addr[1:0]:
  - 0 VALUE: write starts a conversion; read returns the last accepted value.
  - 1 RESULT: read-only; packed BCD, zero-extended.
  - 2 STATUS: bit0 busy, bit1 overflow (sticky), bit2 done (sticky); any write clears bits 1 and 2.
  - 3: reads 0; writes ignored.
- Reset (reset==0, async): state IDLE; value, result, shift regs, bit counter, overflow, done = 0; busy = 0; out_strobe = 0; out_rw = 0; out_addr = 0; out_data = 0.
- FSM: IDLE -> SHIFT -> EMIT -> IDLE.
  - IDLE: write to VALUE latches d_in[IN_BITS-1:0] into value and clears done.
    - If value <= 10^DIGITS-1: load binary shift reg, clear BCD reg, counter = IN_BITS, go to SHIFT.
    - Else: set overflow, force result to all-9s (0x9999 at default), go directly to EMIT.
  - SHIFT: each cycle, every BCD nibble >= 5 gets +3, then {bcd,bin} shifts left by 1 and counter decrements. When counter reaches 0 after the shift, copy BCD reg to result and go to EMIT. Exactly IN_BITS cycles.
  - EMIT: out_strobe = 1, out_rw = 1, out_addr = DISP_ADDR, out_data = result, all registered, for exactly one cycle. Set done; return to IDLE.
- Latency: VALUE write accepted at edge N; SHIFT occupies cycles N+1..N+IN_BITS; out_strobe high in cycle N+IN_BITS+1 (cycle N+1 on overflow). No backpressure: the display accepts every strobe.
- busy = (state != IDLE).
- A VALUE write while busy is dropped: value is unchanged and the conversion in progress is unaffected.
- Writes to STATUS are honoured in any state. If a STATUS write and a done-set (EMIT) occur in the same cycle, set wins.
- Read-during-write returns pre-write register contents.
- Reset mid-SHIFT or mid-EMIT: immediate return to IDLE with all outputs at reset values; no partial out_strobe.
- Nibble adjust is per-nibble 4-bit add; no carry between nibbles, which cannot occur because an adjusted nibble is <= 12 before the shift.

Decomposition:
- Shared package:
  - register offset constants: REG_VALUE=0, REG_RESULT=1, REG_STATUS=2;
  - status bit indices;
  - FSM state encoding (IDLE, SHIFT, EMIT, 2 bits).
- One sub-module, bcd_adjust: combinational, DIGITS nibbles in, applies +3 to each nibble >= 5, DIGITS nibbles out. Instantiated once in the SHIFT datapath.

Test Plan:
- Write VALUE=1234 -> busy high for 15 cycles; out_strobe pulses once in cycle 15 after the write edge with out_addr=0, out_rw=1, out_data=0x00001234; RESULT reads 0x1234; STATUS reads 0x4.
- Write VALUE=0, then VALUE=9999 -> emitted out_data 0x0000, then 0x9999; overflow stays 0.
- Write VALUE=10000 -> out_strobe in cycle 1 after the write with data 0x9999; STATUS=0x6. Write STATUS -> reads 0x0.
- Write VALUE=42, then write VALUE=7 three cycles later -> second write dropped; exactly one out_strobe with data 0x42; VALUE reads 42.
- Write VALUE=5678, pull reset low at cycle 6 for 2 cycles -> out_strobe never asserts; RESULT=0, STATUS=0, busy=0. Next write of 5678 completes normally with 0x5678.
- Write STATUS in the same cycle the block is in EMIT -> done reads 1 afterwards (set wins).
